// File: rtl/alu_issue_unit.sv
// Issue front end for the combinational ALU: registers a request, lets the
// ALU settle for one cycle, captures the result and holds it until taken.
module alu_issue_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             rsp_err,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic             ill_q, ill_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             zero_q, zero_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= 3'b000;
         ill_q   <= 1'b0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         ill_q   <= ill_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      ill_d   = ill_q;
      res_d   = res_q;
      zero_d  = zero_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d = EXEC;
               a_d     = req_a;
               b_d     = req_b;
               ill_d   = req_op[2] & req_op[1];
               // illegal codes never reach the ALU; it sees a harmless add
               op_d    = ill_d ? 3'b000 : req_op;
               err_d   = 1'b0;
            end
         end
         EXEC: begin
            state_d = RESP;
            if (ill_q) begin
               res_d  = '0;
               zero_d = 1'b1;
               err_d  = 1'b1;
            end else begin
               res_d  = alu_result;
               zero_d = alu_zero;
               err_d  = 1'b0;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // reset gates ready so nothing is offered while the unit is held
   assign req_ready  = (state_q == IDLE) & ~rst;
   assign rsp_valid  = (state_q == RESP);
   assign busy       = (state_q != IDLE);
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_op     = op_q;
   assign rsp_result = res_q;
   assign rsp_zero   = zero_q;
   assign rsp_err    = err_q;
   assign op_count   = cnt_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural ALU on its datapath
// port; the counter is narrowed to 2 bits so the wrap is reachable.
module tb_alu_issue_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_a, req_b;
   logic [31:0] alu_a, alu_b;
   logic [2:0]  alu_op;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_zero;
   logic        rsp_err;
   logic        busy;
   logic [1:0]  op_count;

   int checks = 0;
   int errors = 0;
   logic [1:0] exp_cnt = 2'd0;

   alu_issue_unit #(.WIDTH(32), .CNT_W(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero),
      .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
   );

   always #5 clk = ~clk;

   always_comb begin
      alu_result = 32'd0;
      case (alu_op)
         3'b000: alu_result = alu_a + alu_b;
         3'b001: alu_result = alu_a - alu_b;
         3'b010: alu_result = alu_a & alu_b;
         3'b011: alu_result = alu_a | alu_b;
         3'b100: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
         3'b101: alu_result = (alu_a < alu_b) ? 32'd1 : 32'd0;
         default: alu_result = 32'd0;
      endcase
   end
   assign alu_zero = (alu_result == 32'd0);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res,
                         input logic z, input logic e, input string nm);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready: got %b want 1", nm, req_ready);
      end
      req_valid = 1'b1;
      req_op = op;
      req_a = a;
      req_b = b;
      step();
      req_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 1'b0
          || alu_a !== a || alu_b !== b) begin
         errors++;
         $display("FAIL %s exec: busy=%b vld=%b rdy=%b a=%h b=%h want 1 0 0 %h %h",
                  nm, busy, rsp_valid, req_ready, alu_a, alu_b, a, b);
      end
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== res || rsp_zero !== z
          || rsp_err !== e) begin
         errors++;
         $display("FAIL %s resp: vld=%b res=%h z=%b err=%b want 1 %h %b %b",
                  nm, rsp_valid, rsp_result, rsp_zero, rsp_err, res, z, e);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      exp_cnt = exp_cnt + 2'd1;
      checks++;
      if (rsp_valid !== 1'b0 || op_count !== exp_cnt || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s done: vld=%b cnt=%0d rdy=%b want 0 %0d 1",
                  nm, rsp_valid, op_count, req_ready, exp_cnt);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0
          || rsp_err !== 1'b0 || alu_a !== 32'd0 || alu_b !== 32'd0
          || alu_op !== 3'b000 || rsp_result !== 32'd0
          || rsp_zero !== 1'b0 || op_count !== 2'd0) begin
         errors++;
         $display("FAIL reset_vals: rdy=%b vld=%b busy=%b err=%b a=%h b=%h op=%b res=%h z=%b cnt=%0d want all 0",
                  req_ready, rsp_valid, busy, rsp_err, alu_a, alu_b, alu_op,
                  rsp_result, rsp_zero, op_count);
      end
      @(negedge clk);
      rst = 1'b0;
      step();
      checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: rdy=%b busy=%b want 1 0", req_ready, busy);
      end
   endtask

   task automatic test_arith();
      run_op(3'b000, 32'd10, 32'd5, 32'd15, 1'b0, 1'b0, "add");
      run_op(3'b001, 32'hFFFF_FFFB, 32'd3, 32'hFFFF_FFF8, 1'b0, 1'b0, "sub");
   endtask

   task automatic test_logic();
      run_op(3'b010, 32'd8, 32'd3, 32'd0, 1'b1, 1'b0, "and");
      run_op(3'b011, 32'd5, 32'd3, 32'd7, 1'b0, 1'b0, "or");
      run_op(3'b100, 32'hFFFF_FFF6, 32'd15, 32'd1, 1'b0, 1'b0, "slt");
      run_op(3'b101, 32'hFFFF_FFF6, 32'd15, 32'd0, 1'b1, 1'b0, "sltu");
   endtask

   task automatic test_backpressure();
      req_valid = 1'b1;
      req_op = 3'b000;
      req_a = 32'd3;
      req_b = 32'd4;
      step();
      req_op = 3'b011;
      req_a = 32'd12;
      req_b = 32'd3;
      step();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (rsp_valid !== 1'b1 || rsp_result !== 32'd7 || rsp_zero !== 1'b0
             || req_ready !== 1'b0 || alu_a !== 32'd3 || alu_b !== 32'd4
             || alu_op !== 3'b000) begin
            errors++;
            $display("FAIL bp_hold[%0d]: vld=%b res=%h z=%b rdy=%b a=%h b=%h op=%b want 1 7 0 0 3 4 000",
                     i, rsp_valid, rsp_result, rsp_zero, req_ready,
                     alu_a, alu_b, alu_op);
         end
         step();
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      exp_cnt = exp_cnt + 2'd1;
      checks++;
      if (req_ready !== 1'b1 || op_count !== exp_cnt || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: rdy=%b cnt=%0d vld=%b want 1 %0d 0",
                  req_ready, op_count, rsp_valid, exp_cnt);
      end
      step();
      req_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || alu_a !== 32'd12 || alu_op !== 3'b011) begin
         errors++;
         $display("FAIL bp_next_accept: busy=%b a=%h op=%b want 1 c 011",
                  busy, alu_a, alu_op);
      end
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'd15) begin
         errors++;
         $display("FAIL bp_next_resp: vld=%b res=%h want 1 f", rsp_valid, rsp_result);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      exp_cnt = exp_cnt + 2'd1;
   endtask

   task automatic test_illegal();
      req_valid = 1'b1;
      req_op = 3'b111;
      req_a = 32'd1;
      req_b = 32'd1;
      step();
      req_valid = 1'b0;
      checks++;
      if (alu_op !== 3'b000) begin
         errors++;
         $display("FAIL illegal_aluop: got %b want 000", alu_op);
      end
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b1
          || rsp_err !== 1'b1) begin
         errors++;
         $display("FAIL illegal_resp: vld=%b res=%h z=%b err=%b want 1 0 1 1",
                  rsp_valid, rsp_result, rsp_zero, rsp_err);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      exp_cnt = exp_cnt + 2'd1;
      run_op(3'b001, 32'd7, 32'd7, 32'd0, 1'b1, 1'b0, "after_illegal");
   endtask

   task automatic test_reset_mid();
      req_valid = 1'b1;
      req_op = 3'b000;
      req_a = 32'd9;
      req_b = 32'd9;
      step();
      req_valid = 1'b0;
      step();
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL rmid_pre: vld=%b want 1", rsp_valid);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0
          || alu_a !== 32'd0 || rsp_result !== 32'd0 || op_count !== 2'd0) begin
         errors++;
         $display("FAIL rmid_async: vld=%b busy=%b rdy=%b a=%h res=%h cnt=%0d want 0 0 0 0 0 0",
                  rsp_valid, busy, req_ready, alu_a, rsp_result, op_count);
      end
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = 2'd0;
      step();
      checks++;
      if (req_ready !== 1'b1 || op_count !== 2'd0) begin
         errors++;
         $display("FAIL rmid_release: rdy=%b cnt=%0d want 1 0", req_ready, op_count);
      end
   endtask

   task automatic test_wrap();
      run_op(3'b000, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, "wrap1");
      run_op(3'b000, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, "wrap2");
      run_op(3'b000, 32'd3, 32'd3, 32'd6, 1'b0, 1'b0, "wrap3");
      run_op(3'b000, 32'd4, 32'd4, 32'd8, 1'b0, 1'b0, "wrap4");
      checks++;
      if (op_count !== 2'd0) begin
         errors++;
         $display("FAIL wrap_final: cnt=%0d want 0", op_count);
      end
   endtask

   initial begin
      rst = 1'b1;
      req_valid = 1'b0;
      req_op = 3'b000;
      req_a = 32'd0;
      req_b = 32'd0;
      rsp_ready = 1'b0;
      test_reset();
      test_arith();
      test_logic();
      test_backpressure();
      test_illegal();
      test_reset_mid();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Sequential front end that issues operations to the combinational datapath ALU and returns the results. It accepts operation requests (op, A, B) over a valid/ready handshake, drives the ALU's `A`, `B` and `ALUOp` inputs from registers, and captures `ALUResult`/`Zero` after one settle cycle. It then holds the captured result on a valid/ready response port until the consumer takes it. It sits between the multicycle control/operand logic and the `ALU` instance.

## Interface
- `WIDTH`, default 32: operand and result width.
- `CNT_W`, default 16: width of the completed-operation counter.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept a request
- `req_op`  in  3  ALU operation code
- `req_a`, `req_b`  in  WIDTH  operands, two's complement
- `alu_a`, `alu_b`  out  WIDTH  registered operands to the ALU `A`/`B`
- `alu_op`  out  3  registered op to the ALU `ALUOp`
- `alu_result`  in  WIDTH  from the ALU `ALUResult`
- `alu_zero`  in  1  from the ALU `Zero`
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accepts the response
- `rsp_result`  out  WIDTH  captured result
- `rsp_zero`  out  1  captured zero flag
- `rsp_err`  out  1  request carried an illegal op
- `busy`  out  1  high whenever the state is not IDLE
- `op_count`  out  CNT_W  number of completed response handshakes

## Operation
- ALU op contract:
  - 000 = add; 001 = sub; 010 = and; 011 = or.
  - 100 = signed less-than (result 1/0).
  - 101 = unsigned less-than (result 1/0).
  - 110 and 111 are illegal.
- State machine with states IDLE, EXEC and RESP:
  - **IDLE:** `req_ready`=1. When `req_valid`=1, the unit registers `req_a`, `req_b` and `req_op` into `alu_a`, `alu_b` and `alu_op`, latches the illegal flag, and moves to EXEC.
  - **EXEC:** `req_ready`=0. The ALU settles. At the end of the cycle the unit captures `alu_result` and `alu_zero` into `rsp_result` and `rsp_zero`, then moves to RESP.
    - Illegal op: `rsp_result` is forced to 0, `rsp_zero` to 1 and `rsp_err` to 1. `alu_op` is still driven with 000 (add), so the ALU never sees 110/111.
  - **RESP:** `rsp_valid`=1 and `req_ready`=0. The `rsp_*` outputs stay stable until `rsp_ready`=1. On that handshake the unit increments `op_count` and moves to IDLE.
- `alu_a`, `alu_b` and `alu_op` hold their last values in IDLE and RESP. They change only on request acceptance.
- `op_count` wraps from 2^CNT_W−1 to 0 with no saturation or flag.
- `rsp_err` is cleared on each new acceptance.
- A request offered in RESP is not accepted. `req_valid` may stay high; it is accepted on the cycle after return to IDLE.

## Timing
- Reset values:
  - state = IDLE.
  - `req_ready`=1 while `rst` is low and in IDLE; during reset it is 0.
  - `rsp_valid`=0, `busy`=0, `rsp_err`=0.
  - `alu_a`=`alu_b`=`rsp_result`=0, `alu_op`=000, `rsp_zero`=0, `op_count`=0.
- Reset mid-operation: an asserted `rst` immediately forces IDLE and the reset values above. A pending response is discarded and is not counted.
- Accept edge N, then EXEC in cycle N+1, then `rsp_valid` high from cycle N+2.
- Minimum 3 cycles per operation; peak throughput is one op per 3 cycles with `rsp_ready` held at 1.
- Outputs are registered, and `req_ready`, `rsp_valid` and `busy` are decoded from state only. There is no combinational path from `req_valid` or `rsp_ready` to any output.
- Arithmetic is performed by the ALU. This unit does no width extension; operands pass through unchanged.

## Test plan
- Arithmetic:
  - A=10, B=5, op 000: `rsp_valid` 2 cycles after accept, result 15, zero 0.
  - A=−5, B=3, op 001: result 0xFFFFFFF8, zero 0.
- Logic and compare ops:
  - A=8, B=3, op 010: result 0, zero 1.
  - A=5, B=3, op 011: result 7.
  - A=−10, B=15, op 100: result 1.
  - A=−10, B=15, op 101: result 0, zero 1.
- Backpressure: hold `rsp_ready`=0 for 5 cycles with `req_valid` high.
  - `rsp_*` stays stable, `req_ready`=0, and `alu_*` is unchanged.
  - After the handshake, the next request is accepted the following cycle and `op_count` increments by 1.
- Illegal op 111 with A=1, B=1: `alu_op`=000, `rsp_result`=0, `rsp_zero`=1, `rsp_err`=1. The next legal op clears `rsp_err`.
- Reset asserted in RESP: `rsp_valid` drops asynchronously and all outputs take their reset values. After release, `req_ready`=1 and `op_count` is unchanged from 0 or its pre-reset count cleared to 0.
- Counter wrap with CNT_W=2: four completed handshakes take `op_count` 0→1→2→3→0.
